seq_input_collector: RTL and testbench

SEQ_INPUT_COLLECTOR -- requirements
Module: seq_input_collector

---
 rtl/seq_input_collector.sv | 161 ++++++++++++++++
 tb/tb_seq_input_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_input_collector.sv
// Debounced keypad collector: accepts up to eight digits with delete, clear and submit keys.
// One key is tracked at a time; each accepted press commits exactly one action.
module seq_input_collector #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  key_digit,
  input  logic        key_del,
  input  logic        key_clr,
  input  logic        key_ok,
  input  logic        seq_clear,
  output logic [31:0] user_seq,
  output logic [3:0]  input_cnt,
  output logic        seq_full,
  output logic        locked,
  output logic        seq_done,
  output logic        overflow
);

  typedef enum logic [1:0] {StIdle, StPressDb, StHold, StReleaseDb} state_e;

  // Key vector layout: [9:0] digits, [10] delete, [11] clear, [12] submit.
  logic [12:0] raw_keys, sync1_q, k_q;
  assign raw_keys = {key_ok, key_clr, key_del, key_digit};

  state_e      state_q, state_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic [12:0] key_q, key_d;
  logic        commit;

  logic [31:0] seq_q, seq_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      k_q      <= '0;
      state_q  <= StIdle;
      db_cnt_q <= '0;
      key_q    <= '0;
      seq_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_keys;
      k_q      <= sync1_q;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      key_q    <= key_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    key_d    = key_q;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ($onehot(k_q)) begin
          key_d    = k_q;
          db_cnt_d = 20'd1;
          state_d  = StPressDb;
        end
      end
      StPressDb: begin
        if (k_q != key_q) begin
          state_d = StIdle;
        end else if (db_cnt_q == DEBOUNCE_CYCLES) begin
          commit  = 1'b1;
          state_d = StHold;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      end
      StHold: begin
        if (k_q == '0) begin
          db_cnt_d = 20'd1;
          state_d  = StReleaseDb;
        end
      end
      StReleaseDb: begin
        if (k_q != '0) begin
          state_d = StHold;
        end else if (db_cnt_q == DEBOUNCE_CYCLES) begin
          state_d = StIdle;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [3:0] digit_val;
  logic [3:0] cnt_m1;
  logic [4:0] wr_base, del_base;

  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_q[i]) digit_val = 4'(i);
    end
  end

  assign cnt_m1   = cnt_q - 4'd1;
  assign wr_base  = {cnt_q[2:0], 2'b00};
  assign del_base = {cnt_m1[2:0], 2'b00};

  always_comb begin
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    ovf_d    = 1'b0;
    // The external clear wins over any key commit landing in the same cycle.
    if (seq_clear || (commit && key_q[11])) begin
      seq_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (commit && !locked_q) begin
      if (|key_q[9:0]) begin
        if (cnt_q < 4'd8) begin
          seq_d[wr_base +: 4] = digit_val;
          cnt_d               = cnt_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (key_q[10]) begin
        if (cnt_q != 4'd0) begin
          seq_d[del_base +: 4] = 4'h0;
          cnt_d                = cnt_m1;
        end
      end else if (key_q[12]) begin
        if (cnt_q != 4'd0) begin
          locked_d = 1'b1;
          done_d   = 1'b1;
        end
      end
    end
  end

  assign user_seq  = seq_q;
  assign input_cnt = cnt_q;
  assign seq_full  = (cnt_q == 4'd8);
  assign locked    = locked_q;
  assign seq_done  = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_input_collector.sv
// Directed bench for seq_input_collector with a short debounce (4 cycles).
// Pulse outputs are counted on every clock edge and compared as deltas.
module tb_seq_input_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] keys;
  logic        seq_clear;
  logic [31:0] user_seq;
  logic [3:0]  input_cnt;
  logic        seq_full, locked, seq_done, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int done_n   = 0;
  int ovf_n    = 0;
  int done_snap, ovf_snap;

  localparam int KDel = 10;
  localparam int KClr = 11;
  localparam int KOk  = 12;

  always #5 clk = ~clk;

  seq_input_collector #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_digit (keys[9:0]),
    .key_del   (keys[KDel]),
    .key_clr   (keys[KClr]),
    .key_ok    (keys[KOk]),
    .seq_clear (seq_clear),
    .user_seq  (user_seq),
    .input_cnt (input_cnt),
    .seq_full  (seq_full),
    .locked    (locked),
    .seq_done  (seq_done),
    .overflow  (overflow)
  );

  always @(posedge clk) begin
    if (seq_done) done_n++;
    if (overflow) ovf_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [12:0] k);
    @(posedge clk); #1 keys = k;
    repeat (10) @(posedge clk);
    #1 keys = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Checks the commit lands exactly on the sixth edge after the key is first sampled.
  task automatic press_timed(input int d, input logic [3:0] cnt_before, input string tag);
    @(posedge clk); #1 keys = 13'(1 << d);
    repeat (6) @(posedge clk);
    #1 check({tag, "_before"}, 32'(input_cnt), 32'(cnt_before));
    @(posedge clk);
    #1 check({tag, "_at"}, 32'(input_cnt), 32'(cnt_before + 4'd1));
    repeat (3) @(posedge clk);
    #1 keys = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 seq_clear = 1'b1;
    @(posedge clk); #1 seq_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    keys = '0;
    seq_clear = 1'b0;
    #12;
    check("rst_seq", user_seq, 32'h0);
    check("rst_cnt", 32'(input_cnt), 32'd0);
    check("rst_full", 32'(seq_full), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_done", 32'(seq_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    press_timed(3, 4'd0, "d3");
    press_timed(7, 4'd1, "d7");
    press_timed(1, 4'd2, "d1");
    check("seq_371", user_seq, 32'h0000_0173);
    check("cnt_371", 32'(input_cnt), 32'd3);

    // Bounce: digit 5 high for three cycles only.
    @(posedge clk); #1 keys = 13'(1 << 5);
    repeat (3) @(posedge clk);
    #1 keys = '0;
    repeat (10) @(posedge clk);
    #1 check("bounce_seq", user_seq, 32'h0000_0173);
    check("bounce_cnt", 32'(input_cnt), 32'd3);
    press(13'((1 << 2) | (1 << 4)));
    check("multi_seq", user_seq, 32'h0000_0173);
    check("multi_cnt", 32'(input_cnt), 32'd3);

    pulse_clear();
    #1 check("clr_seq", user_seq, 32'h0);
    check("clr_cnt", 32'(input_cnt), 32'd0);
    for (int d = 1; d <= 8; d++) press(13'(1 << d));
    check("full_seq", user_seq, 32'h8765_4321);
    check("full_cnt", 32'(input_cnt), 32'd8);
    check("full_flag", 32'(seq_full), 32'd1);
    ovf_snap = ovf_n;
    press(13'(1 << 9));
    check("ovf_pulses", 32'(ovf_n - ovf_snap), 32'd1);
    check("ovf_seq", user_seq, 32'h8765_4321);
    check("ovf_cnt", 32'(input_cnt), 32'd8);

    pulse_clear();
    press(13'(1 << 1));
    press(13'(1 << 2));
    press(13'(1 << KDel));
    check("del1_seq", user_seq, 32'h0000_0001);
    check("del1_cnt", 32'(input_cnt), 32'd1);
    check("del1_full", 32'(seq_full), 32'd0);
    press(13'(1 << KDel));
    check("del2_seq", user_seq, 32'h0);
    check("del2_cnt", 32'(input_cnt), 32'd0);
    press(13'(1 << KDel));
    check("del3_seq", user_seq, 32'h0);
    check("del3_cnt", 32'(input_cnt), 32'd0);

    done_snap = done_n;
    press(13'(1 << KOk));
    check("ok_empty_done", 32'(done_n - done_snap), 32'd0);
    check("ok_empty_lock", 32'(locked), 32'd0);

    press(13'(1 << 4));
    press(13'(1 << 6));
    done_snap = done_n;
    press(13'(1 << KOk));
    check("ok_done", 32'(done_n - done_snap), 32'd1);
    check("ok_locked", 32'(locked), 32'd1);
    ovf_snap = ovf_n;
    done_snap = done_n;
    press(13'(1 << 9));
    press(13'(1 << KOk));
    check("lock_seq", user_seq, 32'h0000_0064);
    check("lock_cnt", 32'(input_cnt), 32'd2);
    check("lock_ovf", 32'(ovf_n - ovf_snap), 32'd0);
    check("lock_done", 32'(done_n - done_snap), 32'd0);

    // seq_clear asserted in the very cycle the digit commits.
    @(posedge clk); #1 keys = 13'(1 << 7);
    repeat (6) @(posedge clk);
    #1 seq_clear = 1'b1;
    @(posedge clk); #1 seq_clear = 1'b0;
    check("sclr_seq", user_seq, 32'h0);
    check("sclr_cnt", 32'(input_cnt), 32'd0);
    check("sclr_locked", 32'(locked), 32'd0);
    repeat (3) @(posedge clk);
    #1 keys = '0;
    repeat (10) @(posedge clk);
    #1 check("sclr_norepeat", 32'(input_cnt), 32'd0);
    press(13'(1 << 8));
    check("after_sclr_seq", user_seq, 32'h0000_0008);

    press(13'(1 << KOk));
    check("lock2", 32'(locked), 32'd1);
    press(13'(1 << KClr));
    check("clrkey_seq", user_seq, 32'h0);
    check("clrkey_locked", 32'(locked), 32'd0);

    // Reset during press debounce, key still held afterwards.
    press(13'(1 << 5));
    @(posedge clk); #1 keys = 13'(1 << 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("arst_seq", user_seq, 32'h0);
    check("arst_cnt", 32'(input_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rel_before", 32'(input_cnt), 32'd0);
    @(posedge clk);
    #1 check("rel_at", 32'(input_cnt), 32'd1);
    check("rel_seq", user_seq, 32'h0000_0002);
    repeat (10) @(posedge clk);
    #1 keys = '0;
    repeat (10) @(posedge clk);
    #1 check("rel_once", 32'(input_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
